// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
// Applies the four input vectors {a,b} = 00,01,10,11 to a two-input gate under
// test. After each vector it waits SETTLE_CYCLES cycles, then compares the
// gate's output f against the function selected by gate_sel. gate_sel is
// latched at start.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      level request to begin a run (only looked at in IDLE)
//   gate_sel   expected function: 00 AND, 01 OR, 10 XOR, 11 NAND
//   f          output of the gate under test
//   a, b       registered stimulus
//   busy       high in APPLY / SETTLE / CHECK
//   done       one-cycle pulse in DONE
//   pass       result of the last completed run
//   err_count  number of mismatching vectors (0..4)
//   fail_vec   bit i set when vector i mismatched
//   vec_idx    index of the current vector
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results of the previous run held
// APPLY  | new vector on a/b; settle counter loaded
// SETTLE | waiting SETTLE_CYCLES cycles for the gate output to settle
// CHECK  | f compared against the expected value; advance or finish
// DONE   | done pulse; pass updated from err_count

module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [1:0] vec_idx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    logic [2:0] state;
    logic [1:0] sel_q;
    logic [3:0] settle_cnt;
    logic       expected;
    logic       mismatch;
    logic [1:0] next_idx;

    always_comb begin
        expected = 1'b0;
        case (sel_q)
            2'b00:   expected = a & b;
            2'b01:   expected = a | b;
            2'b10:   expected = a ^ b;
            default: expected = ~(a & b);
        endcase
    end

    assign mismatch = (f != expected);
    assign next_idx = vec_idx + 2'd1;

    // Decoded straight from the state register so reset clears them at once.
    assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sel_q      <= 2'b00;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'b0000;
            vec_idx    <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_APPLY;
                        sel_q     <= gate_sel;
                        vec_idx   <= 2'b00;
                        err_count <= 3'd0;
                        fail_vec  <= 4'b0000;
                        pass      <= 1'b0;
                        // Stimulus is set on entry to APPLY so it is already
                        // driven during the APPLY cycle.
                        a         <= 1'b0;
                        b         <= 1'b0;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    // Down-counter: the cycle that sees count 1 is the last
                    // settle cycle.
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count         <= err_count + 3'd1;
                        fail_vec[vec_idx] <= 1'b1;
                    end
                    if (vec_idx == 2'd3) begin
                        state <= S_DONE;
                    end else begin
                        vec_idx <= next_idx;
                        a       <= next_idx[1];
                        b       <= next_idx[0];
                        state   <= S_APPLY;
                    end
                end
                S_DONE: begin
                    pass  <= (err_count == 3'd0);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer. Two instances share clk/rst/start/
// gate_sel: u_dut2 (SETTLE_CYCLES=2) is the main target, and u_dut0
// (SETTLE_CYCLES=0) is used for the zero-settle timing. The gate under test is
// modelled from a truth table. It can be forced stuck-at-0 or made to glitch
// outside the check cycle.

module tb_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] gate_sel;
    logic       f2, f0;

    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fail2;
    logic [1:0] idx2;

    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;
    logic [1:0] idx0;

    logic [1:0] gate_fn;
    int         f_mode;
    bit         in_check;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc;
    int         d0_cyc;
    logic [1:0] ab_at [4];

    always #5 clk = ~clk;

    gate_test_sequencer #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .f(f2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2), .vec_idx(idx2)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .f(f0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0), .vec_idx(idx0)
    );

    function automatic logic gate_model(input logic [1:0] fn, input logic x, input logic y);
        logic [3:0] tt;
        case (fn)
            2'b00:   tt = 4'b1000;   // AND
            2'b01:   tt = 4'b1110;   // OR
            2'b10:   tt = 4'b0110;   // XOR
            default: tt = 4'b0111;   // NAND
        endcase
        return tt[{x, y}];
    endfunction

    // f_mode: 0 correct gate, 1 stuck-at-0, 2 wrong except in the check cycle
    always_comb begin
        f2 = gate_model(gate_fn, a2, b2);
        if (f_mode == 1)
            f2 = 1'b0;
        else if (f_mode == 2 && !in_check)
            f2 = ~gate_model(gate_fn, a2, b2);
        f0 = (f_mode == 1) ? 1'b0 : gate_model(gate_fn, a0, b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Raises start (with gate_sel) for the edge that begins the run; returns
    // #1 after that edge, i.e. inside cycle 1 of the run.
    task automatic launch(input logic [1:0] sel);
        @(negedge clk);
        gate_sel = sel;
        start    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Steps cycle by cycle from cycle 1 until u_dut2 shows done, with a budget.
    // Logs {a,b} in each APPLY cycle and the cycle u_dut0 pulsed done. It can
    // pulse start at poke_cyc and change gate_sel at chg_cyc mid-run.
    task automatic wait_done(input int per, input int poke_cyc, input int chg_cyc,
                             input logic [1:0] chg_sel);
        cyc    = 1;
        d0_cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            in_check = (cyc % per == 0);
            if ((cyc - 1) % per == 0 && cyc <= 4 * per)
                ab_at[(cyc - 1) / per] = {a2, b2};
            if (done0 === 1'b1 && d0_cyc == 0)
                d0_cyc = cyc;
            if (cyc == poke_cyc)
                start = 1'b1;
            else if (cyc == poke_cyc + 1)
                start = 1'b0;
            if (cyc == chg_cyc)
                gate_sel = chg_sel;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_check = 1'b0;
        chk("done_within_budget", 32'(cyc < 200), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        gate_sel = 2'b00;
        gate_fn  = 2'b00;
        f_mode   = 0;
        in_check = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ab",    {a2, b2},       2'b00);
        chk("rst_busy",  busy2,          1'b0);
        chk("rst_done",  done2,          1'b0);
        chk("rst_pass",  pass2,          1'b0);
        chk("rst_err",   err2,           3'd0);
        chk("rst_fail",  fail2,          4'b0000);
        chk("rst_idx",   idx2,           2'b00);
        @(negedge clk);
        rst = 1'b0;

        // AND gate with correct f; a stray start pulse mid-run must be ignored
        gate_fn = 2'b00;
        f_mode  = 0;
        launch(2'b00);
        start = 1'b0;
        chk("and_c1_busy", busy2, 1'b1);
        chk("and_c1_idx",  idx2,  2'b00);
        chk("and_c1_done", done2, 1'b0);
        wait_done(4, 6, -5, 2'b00);
        chk("and_done_cycle", cyc, 17);
        for (int i = 0; i < 4; i++)
            chk($sformatf("and_ab_vec%0d", i), ab_at[i], i);
        chk("and_busy_in_done", busy2, 1'b0);
        chk("zero_settle_done_cycle", d0_cyc, 9);
        @(posedge clk);
        #1;
        chk("and_done_one_cycle", done2, 1'b0);
        chk("and_pass", pass2, 1'b1);
        chk("and_err",  err2,  3'd0);
        chk("and_fail", fail2, 4'b0000);
        chk("zero_settle_pass", pass0, 1'b1);
        chk("zero_settle_err",  err0,  3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ab",   {a2, b2}, 2'b11);
        chk("hold_idx",  idx2,     2'b11);
        chk("hold_pass", pass2,    1'b1);
        chk("hold_busy", busy2,    1'b0);

        // OR expected, f stuck at 0: vectors 1,2,3 mismatch
        f_mode  = 1;
        gate_fn = 2'b01;
        launch(2'b01);
        start = 1'b0;
        wait_done(4, -5, -5, 2'b00);
        chk("stuck_done_cycle", cyc, 17);
        @(posedge clk);
        #1;
        chk("stuck_err",  err2,  3'd3);
        chk("stuck_fail", fail2, 4'b1110);
        chk("stuck_pass", pass2, 1'b0);

        // XOR, f wrong everywhere except the check cycle
        f_mode  = 2;
        gate_fn = 2'b10;
        launch(2'b10);
        start = 1'b0;
        wait_done(4, -5, -5, 2'b00);
        @(posedge clk);
        #1;
        chk("glitch_err",  err2,  3'd0);
        chk("glitch_pass", pass2, 1'b1);

        // NAND gate, start held, gate_sel moved to XOR mid-run
        f_mode  = 0;
        gate_fn = 2'b11;
        launch(2'b11);
        wait_done(4, -5, 5, 2'b10);
        chk("held_done_cycle", cyc, 17);
        @(posedge clk);
        #1;
        chk("held_idle_busy", busy2, 1'b0);
        chk("held_pass",      pass2, 1'b1);
        chk("held_err",       err2,  3'd0);
        @(posedge clk);
        #1;
        chk("rerun_busy", busy2, 1'b1);
        chk("rerun_idx",  idx2,  2'b00);
        chk("rerun_pass_cleared", pass2, 1'b0);
        start = 1'b0;
        // Second run latched XOR against a NAND gate: only vector 00 differs
        wait_done(4, -5, -5, 2'b00);
        chk("rerun_done_cycle", cyc, 17);
        @(posedge clk);
        #1;
        chk("rerun_err",  err2,  3'd1);
        chk("rerun_fail", fail2, 4'b0001);
        chk("rerun_pass", pass2, 1'b0);

        // Reset during SETTLE of vector 2 (cycle 10)
        gate_fn = 2'b00;
        launch(2'b00);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_idx", idx2, 2'b10);
        #3;
        rst = 1'b1;
        #1;
        chk("async_ab",   {a2, b2}, 2'b00);
        chk("async_busy", busy2,    1'b0);
        chk("async_idx",  idx2,     2'b00);
        chk("async_err",  err2,     3'd0);
        chk("async_fail", fail2,    4'b0000);
        chk("async_pass", pass2,    1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_held_done", done2, 1'b0);
            chk("rst_held_busy", busy2, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(2'b00);
        start = 1'b0;
        wait_done(4, -5, -5, 2'b00);
        chk("after_rst_done_cycle", cyc, 17);
        @(posedge clk);
        #1;
        chk("after_rst_pass", pass2, 1'b1);
        chk("after_rst_err",  err2,  3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named clk and rst.
REQ-002 Parameter SETTLE_CYCLES SHALL default to 2, legal range 0..15, and set the number of wait cycles between applying a vector and sampling f.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  level request to begin a run; sampled only in IDLE.
REQ-006 gate_sel  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 f  input  1  output of the gate under test.
REQ-008 a  output  1  registered stimulus to the gate.
REQ-009 b  output  1  registered stimulus to the gate.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of a run.
REQ-012 pass  output  1  result of the last completed run.
REQ-013 err_count  output  3  number of mismatching vectors, 0..4.
REQ-014 fail_vec  output  4  bit i set when vector i ({a,b}=i) mismatched.
REQ-015 vec_idx  output  2  index of the current vector.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE, all transitions on the rising edge of clk.
REQ-017 IDLE with start=1 SHALL go to APPLY, latch gate_sel, and clear vec_idx, err_count, fail_vec and pass.
REQ-018 IDLE with start=0 SHALL stay in IDLE with all outputs held.
REQ-019 APPLY SHALL last one cycle, register a=vec_idx[1] and b=vec_idx[0] (visible from the APPLY cycle onward), and load the settle counter with SETTLE_CYCLES.
REQ-020 APPLY SHALL go to SETTLE, or directly to CHECK when SETTLE_CYCLES=0.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to CHECK.
REQ-022 CHECK SHALL last one cycle and compare f against the expected value computed from the latched gate_sel, a and b.
REQ-023 On a CHECK mismatch, err_count SHALL increment by 1 and fail_vec[vec_idx] SHALL be set to 1.
REQ-024 f SHALL be sampled only in CHECK; f values during APPLY and SETTLE SHALL be ignored.
REQ-025 CHECK with vec_idx<3 SHALL increment vec_idx and go to APPLY; CHECK with vec_idx=3 SHALL go to DONE with no wrap.
REQ-026 DONE SHALL last one cycle, assert done=1, set pass=(err_count==0), and go to IDLE.
REQ-027 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-028 Each vector SHALL take SETTLE_CYCLES+2 cycles.
REQ-029 done SHALL assert in the 4*(SETTLE_CYCLES+2)+1'th cycle after the edge that sampled start.
REQ-030 start SHALL be ignored outside IDLE, and a gate_sel change during a run SHALL have no effect.
REQ-031 If start is still high when the FSM returns to IDLE after DONE, a new run SHALL begin on the next edge.
REQ-032 After DONE, a, b, err_count, fail_vec, vec_idx and pass SHALL hold until the next start or reset.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE and a=b=busy=done=pass=0, err_count=0, fail_vec=0000, vec_idx=00.
REQ-034 rst asserted mid-run SHALL abort the run with no done pulse, and outputs SHALL remain at reset values while rst=1.
REQ-035 The first start after rst deasserts SHALL be honoured normally.

Verification
REQ-036 Pass run: gate_sel=00, f=a&b, SETTLE_CYCLES=2, one-cycle start -> {a,b} steps 00,01,10,11; done pulses 17 cycles after the start edge; pass=1, err_count=0, fail_vec=0000.
REQ-037 Stuck-at-0: gate_sel=01, f tied to 0 -> err_count=3, fail_vec=1110, pass=0.
REQ-038 Reset mid-run: rst pulsed during SETTLE of vector 2 -> all outputs reset asynchronously, no done; a following start completes a normal run.
REQ-039 Held start with gate_sel change: start held high, gate_sel 11->10 during the run -> NAND expectations used throughout; a second run begins the cycle after DONE.
REQ-040 Zero settle: SETTLE_CYCLES=0 -> vector period 2 cycles; done 9 cycles after the start edge.
REQ-041 Settle glitch: f wrong only during SETTLE, correct in CHECK -> err_count=0, pass=1.
